// File: rtl/pcie_cc_pkg.sv
// Shared constants for the completer-completion path: sideband bit map,
// the discontinue beat used to kill a hung packet, and arbiter state codes.
package pcie_cc_pkg;

    localparam int DATA_W = 128;
    localparam int EX_W   = 16;

    // Sideband (data_ex) field positions
    localparam int SOP    = 15;
    localparam int EOP    = 14;
    localparam int ERR    = 13;
    localparam int KEEP_M = 12;
    localparam int KEEP_L = 8;
    localparam int FBE_M  = 7;
    localparam int FBE_L  = 4;
    localparam int LBE_M  = 3;
    localparam int LBE_L  = 0;

    // Terminating beat: EOP with ERR set, no payload
    localparam logic [EX_W-1:0] ABORT_EX = 16'h6000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

    // Saturating 8-bit increment for error counters
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pcie_cc_arb_rr_pick.sv
// Rotate-priority encoder: returns the first set request found searching
// upward from last_i+1 with wrap-around. Purely combinational.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    int cand;

    // Scan from the farthest position down to the nearest one so that the
    // closest candidate after last_i is the final (winning) assignment.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int k = N; k >= 1; k--) begin
            cand = int'(last_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req_i[IW'(cand)]) begin
                found_o = 1'b1;
                idx_o   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/pcie_cc_arb.sv
// Round-robin, packet-locked arbiter in front of the CC write path.
// A channel wins only on an SOP beat and keeps the grant until its EOP.
// Non-SOP beats seen while idle are flushed as protocol errors, and a
// granted packet that stalls for TMO_CYC cycles is closed with an ERR beat.
module pcie_cc_arb
    import pcie_cc_pkg::*;
#(
    parameter int CHAN    = 4,
    parameter int ID_W    = 2,
    parameter int TMO_CYC = 1024
) (
    input  logic                   user_clk,
    input  logic                   user_rst_n,
    input  logic [CHAN*128-1:0]    req_data,
    input  logic [CHAN*16-1:0]     req_data_ex,
    input  logic [CHAN-1:0]        req_valid,
    output logic [CHAN-1:0]        req_ready,
    output logic [127:0]           cc_cplr_data,
    output logic [15:0]            cc_cplr_data_ex,
    output logic                   cc_cplr_wen,
    input  logic                   cc_cplr_ready,
    output logic [ID_W-1:0]        grant_id,
    output logic                   arb_err,
    output logic [15:0]            odbg_info
);

    localparam int             WD_W    = $clog2(TMO_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO_CYC - 1);

    // Per-channel views of the flattened request buses
    logic [DATA_W-1:0] ch_data [CHAN];
    logic [EX_W-1:0]   ch_ex   [CHAN];
    logic [CHAN-1:0]   sop_vec;

    for (genvar gi = 0; gi < CHAN; gi++) begin : g_chan
        assign ch_data[gi] = req_data[gi*DATA_W +: DATA_W];
        assign ch_ex[gi]   = req_data_ex[gi*EX_W +: EX_W];
        assign sop_vec[gi] = req_data_ex[gi*EX_W + SOP];
    end

    // Registered state
    arb_state_e        state_q,      state_d;
    logic [ID_W-1:0]   grant_id_q,   grant_id_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [WD_W-1:0]   wd_q,         wd_d;
    logic              first_q,      first_d;
    logic [DATA_W-1:0] data_q,       data_d;
    logic [EX_W-1:0]   ex_q,         ex_d;
    logic              wen_q,        wen_d;
    logic              arb_err_q,    arb_err_d;
    logic [7:0]        err_cnt_q,    err_cnt_d;
    logic              wd_fire_q,    wd_fire_d;

    logic [CHAN-1:0]   cand_vec;
    logic [CHAN-1:0]   flush_vec;
    logic [CHAN-1:0]   ready_vec;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_found;
    logic              accept;
    logic              err_ev;

    assign cand_vec  = req_valid & sop_vec;
    assign flush_vec = req_valid & ~sop_vec;
    assign accept    = (state_q == ST_BUSY) && req_valid[grant_id_q] && cc_cplr_ready;

    rr_pick #(
        .N  (CHAN),
        .IW (ID_W)
    ) u_pick (
        .req_i   (cand_vec),
        .last_i  (last_grant_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Next-state, beat forwarding, flush/abort handling and watchdog
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        wd_d         = wd_q;
        first_d      = first_q;
        data_d       = data_q;
        ex_d         = ex_q;
        wen_d        = 1'b0;
        wd_fire_d    = 1'b0;
        err_ev       = 1'b0;
        ready_vec    = '0;

        case (state_q)
            ST_IDLE: begin
                // Drop stray mid-packet beats; this can coincide with a grant
                ready_vec = flush_vec;
                err_ev    = |flush_vec;
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    first_d    = 1'b1;
                    wd_d       = '0;
                    state_d    = ST_BUSY;
                end
            end

            ST_BUSY: begin
                ready_vec[grant_id_q] = cc_cplr_ready;
                if (accept) begin
                    wen_d   = 1'b1;
                    data_d  = ch_data[grant_id_q];
                    ex_d    = ch_ex[grant_id_q];
                    wd_d    = '0;
                    first_d = 1'b0;
                    // A second SOP inside a packet is passed on but flagged
                    if (ch_ex[grant_id_q][SOP] && !first_q) begin
                        ex_d[ERR] = 1'b1;
                        err_ev    = 1'b1;
                    end
                    if (ch_ex[grant_id_q][EOP]) begin
                        last_grant_d = grant_id_q;
                        state_d      = ST_IDLE;
                    end
                end else if (cc_cplr_ready) begin
                    // Only source-side stalls count; downstream backpressure never does
                    if (wd_q == WD_LAST) begin
                        wd_fire_d = 1'b1;
                        wd_d      = '0;
                        state_d   = ST_ABORT;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
            end

            ST_ABORT: begin
                if (cc_cplr_ready) begin
                    wen_d        = 1'b1;
                    data_d       = '0;
                    ex_d         = ABORT_EX;
                    err_ev       = 1'b1;
                    last_grant_d = grant_id_q;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        arb_err_d = err_ev;
        err_cnt_d = err_ev ? sat_inc8(err_cnt_q) : err_cnt_q;
    end

    // State and output registers
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= ID_W'(CHAN - 1);
            wd_q         <= '0;
            first_q      <= 1'b0;
            data_q       <= '0;
            ex_q         <= '0;
            wen_q        <= 1'b0;
            arb_err_q    <= 1'b0;
            err_cnt_q    <= '0;
            wd_fire_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            wd_q         <= wd_d;
            first_q      <= first_d;
            data_q       <= data_d;
            ex_q         <= ex_d;
            wen_q        <= wen_d;
            arb_err_q    <= arb_err_d;
            err_cnt_q    <= err_cnt_d;
            wd_fire_q    <= wd_fire_d;
        end
    end

    // Ready is held low while reset is asserted so no beat is consumed then
    assign req_ready       = user_rst_n ? ready_vec : '0;
    assign cc_cplr_data    = data_q;
    assign cc_cplr_data_ex = ex_q;
    assign cc_cplr_wen     = wen_q;
    assign grant_id        = grant_id_q;
    assign arb_err         = arb_err_q;
    assign odbg_info       = {err_cnt_q, 2'b00, (state_q != ST_IDLE), |req_valid,
                              cc_cplr_ready, wd_fire_q, 2'b00};

endmodule

// File: tb/tb_pcie_cc_arb.sv
// Directed bench for pcie_cc_arb: per-channel beat sources fed from tables,
// an output log of written beats, and one task per scenario.
module tb_pcie_cc_arb;

    localparam int CHAN = 4;
    localparam int ID_W = 2;
    localparam int TMO  = 8;
    localparam int SRC_D = 32;

    logic                 user_clk = 1'b0;
    logic                 user_rst_n = 1'b1;
    logic [CHAN*128-1:0]  req_data = '0;
    logic [CHAN*16-1:0]   req_data_ex = '0;
    logic [CHAN-1:0]      req_valid = '0;
    logic [CHAN-1:0]      req_ready;
    logic [127:0]         cc_cplr_data;
    logic [15:0]          cc_cplr_data_ex;
    logic                 cc_cplr_wen;
    logic                 cc_cplr_ready = 1'b0;
    logic [ID_W-1:0]      grant_id;
    logic                 arb_err;
    logic [15:0]          odbg_info;

    int checks = 0;
    int failures = 0;

    pcie_cc_arb #(
        .CHAN    (CHAN),
        .ID_W    (ID_W),
        .TMO_CYC (TMO)
    ) dut (
        .user_clk        (user_clk),
        .user_rst_n      (user_rst_n),
        .req_data        (req_data),
        .req_data_ex     (req_data_ex),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .cc_cplr_data    (cc_cplr_data),
        .cc_cplr_data_ex (cc_cplr_data_ex),
        .cc_cplr_wen     (cc_cplr_wen),
        .cc_cplr_ready   (cc_cplr_ready),
        .grant_id        (grant_id),
        .arb_err         (arb_err),
        .odbg_info       (odbg_info)
    );

    always #5 user_clk = ~user_clk;

    // Source tables
    logic [127:0] src_data [CHAN][SRC_D];
    logic [15:0]  src_ex   [CHAN][SRC_D];
    int           src_rd   [CHAN];
    int           src_wr   [CHAN];

    // Output log and per-cycle history
    int           cyc;
    int           log_n;
    int           log_cyc  [128];
    logic [127:0] log_data [128];
    logic [15:0]  log_ex   [128];
    logic         h_wen    [256];
    logic         h_err    [256];
    logic [ID_W-1:0] h_grant [256];
    logic [15:0]  h_dbg    [256];
    int           err_pulses;
    int           wd_seen;

    function automatic logic [127:0] mk_data(input int ch, input int pkt, input int beat);
        return {4{8'(ch), 8'(pkt), 8'(beat), 8'hA5}};
    endfunction

    function automatic logic [15:0] mk_ex(input logic sop, input logic eop);
        return {sop, eop, 1'b0, 5'd16, 4'hF, 4'h3};
    endfunction

    task automatic push(input int ch, input logic [127:0] d, input logic [15:0] e);
        src_data[ch][src_wr[ch]] = d;
        src_ex[ch][src_wr[ch]]   = e;
        src_wr[ch]++;
    endtask

    task automatic push_pkt(input int ch, input int pkt, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            push(ch, mk_data(ch, pkt, b), mk_ex(b == 0, b == nbeats - 1));
        end
    endtask

    task automatic clear_src();
        for (int c = 0; c < CHAN; c++) begin
            src_rd[c] = 0;
            src_wr[c] = 0;
        end
    endtask

    task automatic drive_inputs();
        for (int c = 0; c < CHAN; c++) begin
            if (src_rd[c] < src_wr[c]) begin
                req_valid[c]              = 1'b1;
                req_data[c*128 +: 128]    = src_data[c][src_rd[c]];
                req_data_ex[c*16 +: 16]   = src_ex[c][src_rd[c]];
            end else begin
                req_valid[c]              = 1'b0;
                req_data[c*128 +: 128]    = '0;
                req_data_ex[c*16 +: 16]   = '0;
            end
        end
    endtask

    // One clock: sample handshakes mid-cycle, observe outputs just after the edge
    task automatic tick();
        logic [CHAN-1:0] acc;
        @(negedge user_clk);
        acc = req_valid & req_ready;
        @(posedge user_clk);
        #1;
        cyc++;
        for (int c = 0; c < CHAN; c++) begin
            if (acc[c]) src_rd[c]++;
        end
        if (cyc < 256) begin
            h_wen[cyc]   = cc_cplr_wen;
            h_err[cyc]   = arb_err;
            h_grant[cyc] = grant_id;
            h_dbg[cyc]   = odbg_info;
        end
        if (cc_cplr_wen && log_n < 128) begin
            log_cyc[log_n]  = cyc;
            log_data[log_n] = cc_cplr_data;
            log_ex[log_n]   = cc_cplr_data_ex;
            log_n++;
        end
        if (arb_err) err_pulses++;
        if (odbg_info[2]) wd_seen++;
        drive_inputs();
    endtask

    task automatic do_reset();
        user_rst_n    = 1'b0;
        cc_cplr_ready = 1'b0;
        clear_src();
        drive_inputs();
        repeat (2) @(posedge user_clk);
        @(negedge user_clk);
        user_rst_n = 1'b1;
        @(posedge user_clk);
        #1;
        cyc        = 0;
        log_n      = 0;
        err_pulses = 0;
        wd_seen    = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cc_cplr_wen !== 1'b0) begin failures++; $display("FAIL reset_wen got=%0b want=0", cc_cplr_wen); end
        checks++; if (cc_cplr_data !== 128'h0) begin failures++; $display("FAIL reset_data got=%h want=0", cc_cplr_data); end
        checks++; if (cc_cplr_data_ex !== 16'h0) begin failures++; $display("FAIL reset_ex got=%h want=0", cc_cplr_data_ex); end
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
        checks++; if (arb_err !== 1'b0) begin failures++; $display("FAIL reset_arb_err got=%0b want=0", arb_err); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0d want=0", grant_id); end
        checks++; if (odbg_info !== 16'h0) begin failures++; $display("FAIL reset_dbg got=%h want=0000", odbg_info); end
        $display("test_reset done");
    endtask

    task automatic test_two_packets();
        int ch, b, ec;
        do_reset();
        cc_cplr_ready = 1'b1;
        push_pkt(0, 0, 3);
        push_pkt(2, 0, 3);
        drive_inputs();
        repeat (12) tick();
        checks++; if (log_n !== 6) begin failures++; $display("FAIL two_pkt_count got=%0d want=6", log_n); end
        for (int i = 0; i < 6; i++) begin
            ch = (i < 3) ? 0 : 2;
            b  = i % 3;
            ec = (i < 3) ? 2 + b : 6 + b;
            checks++;
            if (i >= log_n) begin
                failures++; $display("FAIL two_pkt_beat%0d got=missing want=cyc%0d", i, ec);
            end else if (log_cyc[i] !== ec || log_data[i] !== mk_data(ch, 0, b) || log_ex[i] !== mk_ex(b == 0, b == 2)) begin
                failures++;
                $display("FAIL two_pkt_beat%0d got=cyc%0d ex=%h d=%h want=cyc%0d ex=%h d=%h",
                         i, log_cyc[i], log_ex[i], log_data[i][31:0], ec, mk_ex(b == 0, b == 2), mk_data(ch, 0, b) & 128'hFFFF_FFFF);
            end
        end
        checks++; if (h_grant[1] !== 2'd0) begin failures++; $display("FAIL two_pkt_grant0 got=%0d want=0", h_grant[1]); end
        checks++; if (h_grant[5] !== 2'd2) begin failures++; $display("FAIL two_pkt_grant2 got=%0d want=2", h_grant[5]); end
        checks++; if (err_pulses !== 0) begin failures++; $display("FAIL two_pkt_err got=%0d want=0", err_pulses); end
        $display("test_two_packets done beats=%0d", log_n);
    endtask

    task automatic test_rr_fairness();
        int ch, p, ec;
        do_reset();
        cc_cplr_ready = 1'b1;
        for (int pk = 0; pk < 16; pk++) begin
            for (int c = 0; c < CHAN; c++) push_pkt(c, pk, 1);
        end
        drive_inputs();
        repeat (132) tick();
        checks++; if (log_n !== 64) begin failures++; $display("FAIL rr_count got=%0d want=64", log_n); end
        for (int k = 0; k < 64; k++) begin
            ch = k % 4;
            p  = k / 4;
            ec = 2 + 2 * k;
            checks++;
            if (k >= log_n) begin
                failures++; $display("FAIL rr_pkt%0d got=missing want=ch%0d", k, ch);
            end else if (log_cyc[k] !== ec || log_data[k] !== mk_data(ch, p, 0) || log_ex[k] !== mk_ex(1'b1, 1'b1)) begin
                failures++;
                $display("FAIL rr_pkt%0d got=cyc%0d d=%h want=cyc%0d ch%0d pkt%0d", k, log_cyc[k], log_data[k][31:0], ec, ch, p);
            end
        end
        checks++; if (err_pulses !== 0) begin failures++; $display("FAIL rr_err got=%0d want=0", err_pulses); end
        $display("test_rr_fairness done packets=%0d", log_n);
    endtask

    task automatic test_flush();
        do_reset();
        cc_cplr_ready = 1'b1;
        push(1, mk_data(1, 9, 1), mk_ex(1'b0, 1'b0));
        push_pkt(2, 3, 1);
        drive_inputs();
        #2;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL flush_ready got=%b want=0010", req_ready); end
        tick();
        checks++; if (arb_err !== 1'b1) begin failures++; $display("FAIL flush_arb_err got=%0b want=1", arb_err); end
        checks++; if (cc_cplr_wen !== 1'b0) begin failures++; $display("FAIL flush_no_wen got=%0b want=0", cc_cplr_wen); end
        checks++; if (odbg_info[15:8] !== 8'd1) begin failures++; $display("FAIL flush_err_cnt got=%0d want=1", odbg_info[15:8]); end
        checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL flush_grant got=%0d want=2", grant_id); end
        checks++; if (src_rd[1] !== 1) begin failures++; $display("FAIL flush_dropped got=%0d want=1", src_rd[1]); end
        tick();
        checks++; if (arb_err !== 1'b0) begin failures++; $display("FAIL flush_pulse_len got=%0b want=0", arb_err); end
        checks++;
        if (cc_cplr_wen !== 1'b1 || cc_cplr_data !== mk_data(2, 3, 0) || cc_cplr_data_ex !== mk_ex(1'b1, 1'b1)) begin
            failures++; $display("FAIL flush_grant_beat got=wen%0b ex=%h want=wen1 ex=%h", cc_cplr_wen, cc_cplr_data_ex, mk_ex(1'b1, 1'b1));
        end
        checks++; if (odbg_info[15:8] !== 8'd1) begin failures++; $display("FAIL flush_err_cnt2 got=%0d want=1", odbg_info[15:8]); end
        $display("test_flush done");
    endtask

    task automatic test_watchdog();
        logic ew, ee, ef;
        do_reset();
        cc_cplr_ready = 1'b1;
        push(3, mk_data(3, 1, 0), mk_ex(1'b1, 1'b0));
        drive_inputs();
        repeat (11) tick();
        for (int c = 1; c <= 11; c++) begin
            ew = (c == 2) || (c == 11);
            ee = (c == 11);
            ef = (c == 10);
            checks++;
            if (h_wen[c] !== ew || h_err[c] !== ee || h_dbg[c][2] !== ef) begin
                failures++;
                $display("FAIL wd_cyc%0d got=wen%0b err%0b fire%0b want=wen%0b err%0b fire%0b",
                         c, h_wen[c], h_err[c], h_dbg[c][2], ew, ee, ef);
            end
        end
        checks++;
        if (log_n !== 2 || log_data[0] !== mk_data(3, 1, 0) || log_ex[0] !== mk_ex(1'b1, 1'b0)) begin
            failures++; $display("FAIL wd_first_beat got=n%0d ex=%h want=n2 ex=%h", log_n, log_ex[0], mk_ex(1'b1, 1'b0));
        end
        checks++;
        if (log_data[1] !== 128'h0 || log_ex[1] !== 16'h6000) begin
            failures++; $display("FAIL wd_abort_beat got=d%h ex=%h want=d0 ex=6000", log_data[1][31:0], log_ex[1]);
        end
        checks++;
        if (h_dbg[11][5] !== 1'b0 || h_dbg[11][15:8] !== 8'd1) begin
            failures++; $display("FAIL wd_idle_cnt got=busy%0b cnt%0d want=busy0 cnt1", h_dbg[11][5], h_dbg[11][15:8]);
        end
        // Leftover tail from the aborted channel plus a fresh ch0 packet
        push(3, mk_data(3, 2, 1), mk_ex(1'b0, 1'b1));
        push_pkt(0, 4, 1);
        drive_inputs();
        tick();
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL wd_next_grant got=%0d want=0", grant_id); end
        checks++;
        if (arb_err !== 1'b1 || odbg_info[15:8] !== 8'd2) begin
            failures++; $display("FAIL wd_tail_flush got=err%0b cnt%0d want=err1 cnt2", arb_err, odbg_info[15:8]);
        end
        $display("test_watchdog done");
    endtask

    task automatic test_backpressure();
        int extra;
        int ecyc [4];
        ecyc[0] = 2; ecyc[1] = 3; ecyc[2] = 24; ecyc[3] = 25;
        extra = 0;
        do_reset();
        cc_cplr_ready = 1'b1;
        push_pkt(0, 5, 4);
        drive_inputs();
        for (int i = 0; i < 30; i++) begin
            tick();
            cc_cplr_ready = !(cyc >= 3 && cyc <= 22);
            if (cc_cplr_wen && !cc_cplr_ready) extra++;
        end
        checks++; if (log_n !== 4) begin failures++; $display("FAIL bp_count got=%0d want=4", log_n); end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (b >= log_n) begin
                failures++; $display("FAIL bp_beat%0d got=missing want=cyc%0d", b, ecyc[b]);
            end else if (log_cyc[b] !== ecyc[b] || log_data[b] !== mk_data(0, 5, b) || log_ex[b] !== mk_ex(b == 0, b == 3)) begin
                failures++; $display("FAIL bp_beat%0d got=cyc%0d ex=%h want=cyc%0d ex=%h", b, log_cyc[b], log_ex[b], ecyc[b], mk_ex(b == 0, b == 3));
            end
        end
        checks++; if (extra !== 1) begin failures++; $display("FAIL bp_inflight got=%0d want=1", extra); end
        checks++; if (wd_seen !== 0 || err_pulses !== 0) begin failures++; $display("FAIL bp_no_abort got=fire%0d err%0d want=0 0", wd_seen, err_pulses); end
        for (int c = 1; c <= 24; c++) begin
            checks++;
            if (h_grant[c] !== 2'd0 || h_dbg[c][5] !== 1'b1) begin
                failures++; $display("FAIL bp_hold_cyc%0d got=grant%0d busy%0b want=grant0 busy1", c, h_grant[c], h_dbg[c][5]);
            end
        end
        $display("test_backpressure done beats=%0d", log_n);
    endtask

    task automatic test_reset_mid();
        do_reset();
        cc_cplr_ready = 1'b1;
        push_pkt(0, 6, 1);
        drive_inputs();
        repeat (2) tick();
        push_pkt(2, 7, 3);
        drive_inputs();
        repeat (2) tick();
        checks++; if (cc_cplr_wen !== 1'b1 || grant_id !== 2'd2) begin failures++; $display("FAIL rstmid_pre got=wen%0b grant%0d want=wen1 grant2", cc_cplr_wen, grant_id); end
        #2;
        user_rst_n = 1'b0;
        #1;
        checks++;
        if (cc_cplr_wen !== 1'b0 || cc_cplr_data !== 128'h0 || cc_cplr_data_ex !== 16'h0) begin
            failures++; $display("FAIL rstmid_out got=wen%0b ex=%h want=wen0 ex=0000", cc_cplr_wen, cc_cplr_data_ex);
        end
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL rstmid_ready got=%b want=0000", req_ready); end
        checks++;
        if (arb_err !== 1'b0 || grant_id !== 2'd0 || odbg_info[15:8] !== 8'd0 || odbg_info[5] !== 1'b0) begin
            failures++; $display("FAIL rstmid_state got=err%0b grant%0d dbg=%h want=err0 grant0", arb_err, grant_id, odbg_info);
        end
        clear_src();
        drive_inputs();
        @(posedge user_clk);
        @(negedge user_clk);
        user_rst_n = 1'b1;
        @(posedge user_clk);
        #1;
        cyc = 0;
        log_n = 0;
        push_pkt(1, 8, 1);
        push_pkt(0, 8, 1);
        drive_inputs();
        tick();
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rstmid_first_grant got=%0d want=0", grant_id); end
        repeat (2) tick();
        checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL rstmid_second_grant got=%0d want=1", grant_id); end
        checks++;
        if (log_n < 1 || log_data[0] !== mk_data(0, 8, 0) || log_cyc[0] !== 2) begin
            failures++; $display("FAIL rstmid_first_beat got=n%0d cyc%0d want=ch0 at cyc2", log_n, log_cyc[0]);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_two_packets();
        test_rr_fairness();
        test_flush();
        test_watchdog();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
